// File: rtl/acc_sched.sv
// acc_sched: shares one top_acc accelerator between two requesters.
// Requesters are served one at a time and alternate under round-robin arbitration.
// The block drives the accelerator start pulse and waits for done.
// It then returns a tagged completion to the requester that was served.
// Optional feature macro: ACC_SCHED_TIMEOUT_EN. When it is defined, a RUN-phase
// watchdog is compiled in and a job that times out completes with cpl_err_o=1.
module acc_sched #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned TMO_W = 16
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [1:0]         req_i,
  input  logic [2*TAG_W-1:0] req_tag_i,
  output logic [1:0]         gnt_o,
  output logic               acc_sel_o,
  output logic               acc_busy_o,
  output logic               acc_start_o,
  input  logic               acc_done_i,
  input  logic [TMO_W-1:0]   tmo_limit_i,
  output logic [1:0]         cpl_valid_o,
  input  logic [1:0]         cpl_ready_i,
  output logic [TAG_W-1:0]   cpl_tag_o,
  output logic               cpl_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_CPL} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_sel;
  logic             w_sel_next;
  logic             r_prio;
  logic [TAG_W-1:0] r_tag;
  logic [1:0]       r_gnt;
  logic             r_start;
  logic             r_busy;
  logic [1:0]       r_valid;
  logic             w_win;
  logic             w_arb;
  logic             w_accept;
  logic             w_tmo;

`ifdef ACC_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] r_cnt;
  logic             r_hit;
  logic             r_err;

  // RUN-cycle counter; the limit match is registered, so a timeout exits RUN
  // one cycle after the counter reaches limit-1 (err appears L+1 cycles into RUN).
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt <= '0;
      r_hit <= 1'b0;
    end else if (r_state == S_START) begin
      r_cnt <= '0;
      r_hit <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_hit <= (tmo_limit_i != '0) && (r_cnt == tmo_limit_i - 1'b1);
    end
  end

  // Error flag: cleared when a job is granted, set when RUN ends by timeout (done wins ties).
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_err <= 1'b0;
    end else if (w_arb) begin
      r_err <= 1'b0;
    end else if (r_state == S_RUN && !acc_done_i && w_tmo) begin
      r_err <= 1'b1;
    end
  end

  assign w_tmo     = r_hit;
  assign cpl_err_o = r_err;
`else
  logic w_unused_tmo;

  assign w_unused_tmo = ^tmo_limit_i;
  assign w_tmo        = 1'b0;
  assign cpl_err_o    = 1'b0;
`endif

  assign w_arb    = (r_state == S_IDLE) && (|req_i);
  assign w_accept = cpl_ready_i[r_sel];

  // Arbitration and next-state decode.
  always_comb begin
    w_next = r_state;
    case (req_i)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      default: w_win = r_prio;
    endcase
    case (r_state)
      S_IDLE:  if (|req_i) w_next = S_START;
      S_START: w_next = S_RUN;
      S_RUN:   if (acc_done_i || w_tmo) w_next = S_CPL;
      S_CPL:   if (w_accept) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_sel_next = w_arb ? w_win : r_sel;
  end

  // State, job context and registered outputs; outputs are loaded from the next state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
      r_prio  <= 1'b0;
      r_tag   <= '0;
      r_gnt   <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= '0;
    end else begin
      r_state <= w_next;
      if (w_arb) begin
        r_sel <= w_win;
        r_tag <= w_win ? req_tag_i[2*TAG_W-1:TAG_W] : req_tag_i[TAG_W-1:0];
      end
      if (r_state == S_CPL && w_accept) begin
        r_prio <= ~r_sel;
      end
      r_gnt   <= (w_next == S_START) ? (w_sel_next ? 2'b10 : 2'b01) : 2'b00;
      r_start <= (w_next == S_START);
      r_busy  <= (w_next != S_IDLE);
      r_valid <= (w_next == S_CPL) ? (w_sel_next ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  assign gnt_o       = r_gnt;
  assign acc_sel_o   = r_sel;
  assign acc_busy_o  = r_busy;
  assign acc_start_o = r_start;
  assign cpl_valid_o = r_valid;
  assign cpl_tag_o   = r_tag;

endmodule
